// File: rtl/memory2_bram_responder.sv
// memory2_bram_responder
// Responder end of the memory2 BRAM interface. Holds DEPTH lines of 512 bits
// (16 x 32-bit floats each). It services one read and one line write per cycle
// and returns read data after a fixed READ_LATENCY with a valid strobe. After
// reset, or on clear_start, it zeroes every line before it accepts traffic.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   clear_start        one-cycle pulse that re-zeroes the whole memory
//   ready              high when requests are accepted (not clearing)
//   req_re, req_raddr  read strobe and line address
//   wr_we, wr_waddr,   write strobe, line address and full-line data
//   wr_wdata
//   rd_valid, rd_rdata read data strobe and data (data holds while not valid)
//   oob_count          saturating count of out-of-range accesses
module memory2_bram_responder #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_start,
    output logic          ready,
    input  logic          req_re,
    input  logic [15:0]   req_raddr,
    input  logic          wr_we,
    input  logic [15:0]   wr_waddr,
    input  logic [511:0]  wr_wdata,
    output logic          rd_valid,
    output logic [511:0]  rd_rdata,
    output logic [15:0]   oob_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e                               state_q, state_d;
    logic [AW-1:0]                        clr_addr_q, clr_addr_d;
    logic                                 clr_we;
    logic [READ_LATENCY-1:0]              valid_q, valid_d;
    logic [READ_LATENCY-1:0][511:0]       data_q, data_d;
    logic [15:0]                          oob_count_q, oob_count_d;
    logic [511:0]                         mem_q [DEPTH];

    logic         rd_acc, wr_acc, rd_in, wr_in, fwd;
    logic [511:0] rd_line;
    logic [1:0]   oob_inc;
    logic [16:0]  oob_sum;

    // Clear sequencer
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        unique case (state_q)
            StClear: begin
                clr_we = 1'b1;
                if (clear_start) begin
                    clr_addr_d = '0;
                end else if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d    = StReady;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            StReady: begin
                if (clear_start) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    assign ready  = (state_q == StReady);
    assign rd_acc = ready & req_re;
    assign wr_acc = ready & wr_we;
    assign rd_in  = 32'(req_raddr) < DEPTH;
    assign wr_in  = 32'(wr_waddr) < DEPTH;
    // Write-first: a same-cycle write to the read line is returned by the read
    assign fwd    = wr_acc & wr_in & (wr_waddr == req_raddr);

    always_comb begin
        rd_line = '0;
        if (rd_in) begin
            rd_line = fwd ? wr_wdata : mem_q[req_raddr[AW-1:0]];
        end
    end

    // Read pipeline; each data stage only loads with a valid beat so the
    // output stage holds its last value between reads.
    always_comb begin
        valid_d    = '0;
        data_d     = data_q;
        valid_d[0] = rd_acc;
        if (rd_acc) begin
            data_d[0] = rd_line;
        end
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) begin
                data_d[i] = data_q[i-1];
            end
        end
    end

    // Out-of-range reads and writes may land together and add 2
    always_comb begin
        oob_inc     = {1'b0, rd_acc & ~rd_in} + {1'b0, wr_acc & ~wr_in};
        oob_sum     = {1'b0, oob_count_q} + 17'(oob_inc);
        oob_count_d = oob_sum[16] ? 16'hFFFF : oob_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StClear;
            clr_addr_q  <= '0;
            valid_q     <= '0;
            data_q      <= '0;
            oob_count_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            oob_count_q <= oob_count_d;
        end
    end

    // Storage has no reset; the clear sequence that follows reset zeroes it
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem_q[clr_addr_q] <= '0;
            end else if (wr_acc && wr_in) begin
                mem_q[wr_waddr[AW-1:0]] <= wr_wdata;
            end
        end
    end

    assign rd_valid  = valid_q[READ_LATENCY-1];
    assign rd_rdata  = data_q[READ_LATENCY-1];
    assign oob_count = oob_count_q;

endmodule

// File: tb/tb_memory2_bram_responder.sv
module tb_memory2_bram_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear_start;
    logic         ready;
    logic         req_re;
    logic [15:0]  req_raddr;
    logic         wr_we;
    logic [15:0]  wr_waddr;
    logic [511:0] wr_wdata;
    logic         rd_valid;
    logic [511:0] rd_rdata;
    logic [15:0]  oob_count;

    int checks = 0;
    int errors = 0;

    localparam logic [511:0] ZERO = '0;
    localparam logic [511:0] ONES = {512{1'b1}};
    localparam logic [511:0] DEAD = {16{32'hDEADBEEF}};

    memory2_bram_responder #(
        .DEPTH       (16),
        .READ_LATENCY(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear_start(clear_start),
        .ready      (ready),
        .req_re     (req_re),
        .req_raddr  (req_raddr),
        .wr_we      (wr_we),
        .wr_waddr   (wr_waddr),
        .wr_wdata   (wr_wdata),
        .rd_valid   (rd_valid),
        .rd_rdata   (rd_rdata),
        .oob_count  (oob_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [511:0] data);
        wr_we    = 1'b1;
        wr_waddr = addr;
        wr_wdata = data;
        step();
        wr_we    = 1'b0;
    endtask

    // Called right after the edge that starts a clear: 15 more cycles low, then high
    task automatic wait_ready(input string tag);
        for (int i = 0; i < 15; i++) begin
            step();
            chk({tag, "_ready_lo"}, 512'(ready), 512'(0));
        end
        step();
        chk({tag, "_ready_hi"}, 512'(ready), 512'(1));
    endtask

    logic [511:0] exp_line;

    initial begin
        reset       = 1'b1;
        clear_start = 1'b0;
        req_re      = 1'b0;
        req_raddr   = '0;
        wr_we       = 1'b0;
        wr_waddr    = '0;
        wr_wdata    = '0;
        step();
        step();
        chk("rst_ready", 512'(ready), 512'(0));
        chk("rst_valid", 512'(rd_valid), 512'(0));
        chk("rst_rdata", rd_rdata, ZERO);
        chk("rst_oob", 512'(oob_count), 512'(0));
        reset = 1'b0;

        // 1: initial clear, then read line 5
        wait_ready("t1");
        req_re = 1'b1; req_raddr = 16'd5;
        step();
        req_re = 1'b0;
        chk("t1_valid_p1", 512'(rd_valid), 512'(0));
        step();
        chk("t1_valid_p2", 512'(rd_valid), 512'(1));
        chk("t1_data", rd_rdata, ZERO);

        // 2: write word 7 of line 3, read it back
        exp_line = ZERO;
        exp_line[255:224] = 32'h3F800000;
        wr(16'd3, exp_line);
        req_re = 1'b1; req_raddr = 16'd3;
        step();
        req_re = 1'b0;
        step();
        chk("t2_valid", 512'(rd_valid), 512'(1));
        chk("t2_data", rd_rdata, exp_line);

        // 3: write-first forwarding, then later write does not disturb in-flight read
        wr_we = 1'b1; wr_waddr = 16'd4; wr_wdata = DEAD;
        req_re = 1'b1; req_raddr = 16'd4;
        step();
        req_re = 1'b0; wr_wdata = ZERO;
        step();
        wr_we = 1'b0;
        chk("t3_fwd_valid", 512'(rd_valid), 512'(1));
        chk("t3_fwd_data", rd_rdata, DEAD);
        req_re = 1'b1; req_raddr = 16'd4;
        step();
        req_re = 1'b0;
        chk("t3_gap_valid", 512'(rd_valid), 512'(0));
        chk("t3_hold_data", rd_rdata, DEAD);
        step();
        chk("t3_rd2_valid", 512'(rd_valid), 512'(1));
        chk("t3_rd2_data", rd_rdata, ZERO);

        // 4: back-to-back reads return in order
        for (int i = 0; i < 4; i++) begin
            wr(16'(i), {480'h0, 32'h10 + 32'(i)});
        end
        for (int i = 0; i < 4; i++) begin
            req_re = 1'b1; req_raddr = 16'(i);
            step();
            if (i == 0) begin
                chk("t4_valid_lat", 512'(rd_valid), 512'(0));
            end else begin
                chk("t4_valid", 512'(rd_valid), 512'(1));
                chk("t4_data", rd_rdata, {480'h0, 32'h10 + 32'(i - 1)});
            end
        end
        req_re = 1'b0;
        step();
        chk("t4_valid_last", 512'(rd_valid), 512'(1));
        chk("t4_data_last", rd_rdata, {480'h0, 32'h13});
        step();
        chk("t4_valid_end", 512'(rd_valid), 512'(0));

        // 5: out-of-range read and write together
        req_re = 1'b1; req_raddr = 16'd16;
        wr_we = 1'b1; wr_waddr = 16'd20; wr_wdata = ONES;
        step();
        req_re = 1'b0; wr_we = 1'b0;
        chk("t5_oob", 512'(oob_count), 512'(2));
        step();
        chk("t5_valid", 512'(rd_valid), 512'(1));
        chk("t5_data", rd_rdata, ZERO);
        req_re = 1'b1; req_raddr = 16'd4;
        step();
        req_re = 1'b0;
        step();
        chk("t5_mem_unchanged", rd_rdata, ZERO);

        // 6: clear_start with a same-cycle read, requests ignored while clearing
        for (int i = 0; i < 16; i++) begin
            wr(16'(i), ONES);
        end
        clear_start = 1'b1; req_re = 1'b1; req_raddr = 16'd2;
        step();
        clear_start = 1'b0; req_re = 1'b0;
        chk("t6_ready_drop", 512'(ready), 512'(0));
        step();
        chk("t6_inflight_valid", 512'(rd_valid), 512'(1));
        chk("t6_inflight_data", rd_rdata, ONES);
        req_re = 1'b1; req_raddr = 16'd1;
        wr_we = 1'b1; wr_waddr = 16'd20; wr_wdata = ONES;
        for (int i = 0; i < 14; i++) begin
            step();
            chk("t6_clr_ready", 512'(ready), 512'(0));
            chk("t6_clr_valid", 512'(rd_valid), 512'(0));
            chk("t6_clr_oob", 512'(oob_count), 512'(2));
        end
        req_re = 1'b0; wr_we = 1'b0;
        step();
        chk("t6_ready_back", 512'(ready), 512'(1));
        chk("t6_oob_kept", 512'(oob_count), 512'(2));
        for (int i = 0; i < 18; i++) begin
            req_re = (i < 16); req_raddr = 16'(i);
            step();
            if (i >= 1 && i <= 16) begin
                chk("t6_post_valid", 512'(rd_valid), 512'(1));
                chk("t6_post_data", rd_rdata, ZERO);
            end
        end
        req_re = 1'b0;

        // Reset in the middle of a clear restarts the full clear
        wr(16'd7, ONES);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_ready", 512'(ready), 512'(0));
        chk("t6_rst_oob", 512'(oob_count), 512'(0));
        wait_ready("t6_rst");
        req_re = 1'b1; req_raddr = 16'd7;
        step();
        req_re = 1'b0;
        step();
        chk("t6_rst_valid", 512'(rd_valid), 512'(1));
        chk("t6_rst_data", rd_rdata, ZERO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
